// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: read-only QSPI flash target (0x0B/0xBB/0xEB)
// with a clk-domain preload port and synchronised cs/sclk edge detect.

module qspi_flash_responder #(
  parameter int MEM_AW      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk,
  input  logic [3:0]        sio_i,
  output logic [3:0]        sio_o,
  output logic [3:0]        sio_oe,
  input  logic              mem_we,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_e;

  typedef enum logic [1:0] {
    M_X1,
    M_X2,
    M_X4
  } mode_e;

  state_e state_q, state_d;
  mode_e  mode_q, mode_d, cmd_mode;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   armed_q;
  logic cs_s, sclk_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [4:0]  cnt_q, cnt_d;
  logic [6:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d, addr_nxt, addr_shift;
  logic [7:0]  sh_q, sh_d, sh_next;
  logic [7:0]  mem_cur, mem_nxt;
  logic [3:0]  sio_o_q, sio_o_d, oe_q, oe_d;
  logic [3:0]  oe_pat, lane_bits;
  logic        busy_q, busy_d, err_q, err_d;
  logic [7:0]  cmd_byte;
  logic        cmd_ok;
  logic [4:0]  addr_last, dmy_last, beat_last;

  logic [7:0] mem_q [2**MEM_AW];

  // cs/sclk synchronisers; armed_q blocks a fall until cs was seen high
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(cs);
      sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(sclk);
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_q | (fill_q[SYNC_STAGES] & cs_s);
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  always_ff @(posedge clk) begin
    if (mem_we && !busy_q) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign addr_nxt = addr_q + 24'd1;
  assign mem_cur  = mem_q[addr_q[MEM_AW-1:0]];
  assign mem_nxt  = mem_q[addr_nxt[MEM_AW-1:0]];

  always_comb begin
    cmd_byte = {cmd_q, sio_i[0]};
    cmd_ok   = 1'b1;
    cmd_mode = M_X1;
    unique case (1'b1)
      cmd_byte == 8'h0B: cmd_mode = M_X1;
      cmd_byte == 8'hBB: cmd_mode = M_X2;
      cmd_byte == 8'hEB: cmd_mode = M_X4;
      default:           cmd_ok   = 1'b0;
    endcase
  end

  // lane width dependent counts, shifts and drive patterns
  always_comb begin
    addr_last  = 5'd23;
    dmy_last   = 5'd7;
    beat_last  = 5'd7;
    oe_pat     = 4'b0010;
    addr_shift = {addr_q[22:0], sio_i[0]};
    lane_bits  = {2'b00, sh_q[7], 1'b0};
    sh_next    = {sh_q[6:0], 1'b0};
    case (mode_q)
      M_X2: begin
        addr_last  = 5'd11;
        dmy_last   = 5'd3;
        beat_last  = 5'd3;
        oe_pat     = 4'b0011;
        addr_shift = {addr_q[21:0], sio_i[1:0]};
        lane_bits  = {2'b00, sh_q[7:6]};
        sh_next    = {sh_q[5:0], 2'b00};
      end
      M_X4: begin
        addr_last  = 5'd5;
        dmy_last   = 5'd5;
        beat_last  = 5'd1;
        oe_pat     = 4'b1111;
        addr_shift = {addr_q[19:0], sio_i};
        lane_bits  = sh_q[7:4];
        sh_next    = {sh_q[3:0], 4'b0000};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) state_d = S_CMD;
        end
        S_CMD: begin
          if (sclk_rise && cnt_q == 5'd7) begin
            state_d = cmd_ok ? S_ADDR : S_IGNORE;
          end
        end
        S_ADDR: begin
          if (sclk_rise && cnt_q == addr_last) begin
            state_d = S_DUMMY;
          end
        end
        S_DUMMY: begin
          if (sclk_rise && cnt_q == dmy_last) begin
            state_d = S_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    sh_d    = sh_q;
    sio_o_d = sio_o_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    if (cs_rise) begin
      busy_d  = 1'b0;
      oe_d    = 4'b0000;
      sio_o_d = 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            busy_d = 1'b1;
            cnt_d  = 5'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            cmd_d = cmd_byte[6:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d  = 5'd0;
              mode_d = cmd_mode;
              err_d  = ~cmd_ok;
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            addr_d = addr_shift;
            cnt_d  = (cnt_q == addr_last) ? 5'd0 : cnt_q + 5'd1;
          end
        end
        S_DUMMY: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == dmy_last) begin
              cnt_d = 5'd0;
              sh_d  = mem_cur;
            end
          end
        end
        S_DATA: begin
          if (sclk_fall) begin
            oe_d    = oe_pat;
            sio_o_d = lane_bits;
            sh_d    = sh_next;
            cnt_d   = cnt_q + 5'd1;
            if (cnt_q == beat_last) begin
              cnt_d  = 5'd0;
              sh_d   = mem_nxt;
              addr_d = addr_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      mode_q  <= M_X1;
      sh_q    <= '0;
      sio_o_q <= '0;
      oe_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      sh_q    <= sh_d;
      sio_o_q <= sio_o_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // release the bus in the very cycle cs rise is seen
  assign sio_oe  = oe_q & {4{~cs_rise}};
  assign sio_o   = sio_o_q;
  assign busy    = busy_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: random QSPI read frames checked against a
// byte-array flash model, plus fixed-value reads that pin the model.

module tb_qspi_flash_responder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic          sclk;
  logic [3:0]    sio_i;
  logic [3:0]    sio_o;
  logic [3:0]    sio_oe;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          cmd_err;

  always #5 clk = ~clk;

  qspi_flash_responder #(
    .MEM_AW(AW),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .sclk(sclk),
    .sio_i(sio_i),
    .sio_o(sio_o),
    .sio_oe(sio_oe),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  int checks = 0;
  int fails = 0;
  int err_seen = 0;
  int mode = 0;
  logic [3:0] exp_sio, exp_oe;
  logic chk_busy, exp_busy;
  logic [7:0] mem_m [256];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // mode 1: bus must be released; mode 2: bus must carry exp_sio
  task automatic monitor();
    forever begin
      @(posedge clk);
      #1;
      if (cmd_err === 1'b1) err_seen++;
      if (mode == 1) begin
        chk("oe_quiet", 64'(sio_oe), 64'h0);
      end else if (mode == 2) begin
        chk("oe_data", 64'(sio_oe), 64'(exp_oe));
        chk("sio_data", 64'(sio_o & exp_oe), 64'(exp_sio));
      end
      if (chk_busy) chk("busy", 64'(busy), 64'(exp_busy));
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    mem_we = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    @(negedge clk);
    mem_we = 1'b0;
    mem_m[a] = d;
  endtask

  // one sclk period; the junk write lands while busy and must be dropped
  task automatic cyc(input logic [3:0] d, input bit junk,
                     output logic [3:0] smp);
    sio_i = d;
    if (junk) begin
      @(negedge clk);
      mem_we = 1'b1;
      mem_addr = 8'($urandom_range(4, 7));
      mem_wdata = 8'($urandom);
      @(negedge clk);
      mem_we = 1'b0;
      wait_clk(4);
    end else begin
      wait_clk(6);
    end
    sclk = 1'b1;
    smp = sio_o;
    wait_clk(6);
    sclk = 1'b0;
  endtask

  function automatic logic [3:0] exp_lines(input logic [23:0] addr,
                                           input int k, input int w);
    int bpb, idx, sh;
    logic [7:0] b;
    logic [3:0] bits;
    bpb = 8 / w;
    idx = (int'(addr) % 256 + k / bpb) % 256;
    b = mem_m[idx];
    sh = 8 - w * (k % bpb + 1);
    bits = 4'((int'(b) >> sh) & ((1 << w) - 1));
    return (w == 1) ? {2'b00, bits[0], 1'b0} : bits;
  endfunction

  task automatic frame(input logic [7:0] cmd, input logic [23:0] addr,
                       input int ncyc, input int rst_at,
                       output logic [63:0] cap);
    int w, acyc, dcyc, e0, nrun;
    bit ok;
    logic [3:0] s, d, m, oe_p, ext;
    ok = (cmd == 8'h0B) || (cmd == 8'hBB) || (cmd == 8'hEB);
    w = (cmd == 8'hBB) ? 2 : (cmd == 8'hEB) ? 4 : 1;
    acyc = 24 / w;
    dcyc = (cmd == 8'h0B) ? 8 : (cmd == 8'hBB) ? 4 : 6;
    oe_p = (w == 1) ? 4'b0010 : (w == 2) ? 4'b0011 : 4'b1111;
    m = 4'((1 << w) - 1);
    nrun = (rst_at >= 0) ? rst_at : ncyc;
    cap = '0;
    e0 = err_seen;
    mode = 1;
    cs = 1'b0;
    chk_busy = 1'b0;
    wait_clk(4);
    exp_busy = 1'b1;
    chk_busy = 1'b1;
    wait_clk(2);
    for (int i = 7; i >= 0; i--) cyc({3'($urandom), cmd[i]}, 1'b0, s);
    if (!ok) begin
      for (int i = 0; i < 16; i++) cyc(4'($urandom), i == 0, s);
    end else begin
      for (int i = 0; i < acyc; i++) begin
        d = 4'($urandom);
        d = (d & ~m) | (4'(addr >> (24 - w * (i + 1))) & m);
        cyc(d, 1'b0, s);
      end
      for (int i = 0; i < dcyc; i++) cyc(4'($urandom), i == 0, s);
      for (int k = 0; k < nrun; k++) begin
        mode = 0;
        sio_i = 4'($urandom);
        wait_clk(4);
        exp_oe = oe_p;
        exp_sio = exp_lines(addr, k, w);
        mode = 2;
        wait_clk(2);
        sclk = 1'b1;
        s = sio_o;
        ext = (w == 1) ? {3'b000, s[1]} : (s & oe_p);
        cap = (cap << w) | 64'(ext);
        wait_clk(6);
        sclk = 1'b0;
      end
    end
    mode = 0;
    if (rst_at >= 0) begin
      chk_busy = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_oe", 64'(sio_oe), 64'h0);
      chk("rst_mid_busy", 64'(busy), 64'h0);
      @(negedge clk);
      reset = 1'b0;
      exp_busy = 1'b0;
      chk_busy = 1'b1;
      mode = 1;
      e0 = err_seen;
      for (int i = 0; i < 48; i++) cyc(4'($urandom), 1'b0, s);
    end
    wait_clk(6);
    cs = 1'b1;
    chk_busy = 1'b0;
    wait_clk(5);
    exp_busy = 1'b0;
    chk_busy = 1'b1;
    mode = 1;
    chk("cmd_err_pulses", 64'(err_seen - e0), (ok || rst_at >= 0) ? 64'd0 : 64'd1);
  endtask

  initial begin
    logic [63:0] cap;
    logic [7:0] c;
    reset = 1'b1;
    cs = 1'b1;
    sclk = 1'b0;
    sio_i = 4'h0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    exp_sio = '0;
    exp_oe = '0;
    exp_busy = 1'b0;
    chk_busy = 1'b0;
    fork
      monitor();
    join_none
    wait_clk(5);
    @(posedge clk);
    #1;
    chk("rst_sio_oe", 64'(sio_oe), 64'h0);
    chk("rst_sio_o", 64'(sio_o), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cmd_err", 64'(cmd_err), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_clk(5);
    mode = 1;
    chk_busy = 1'b1;

    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    preload(8'h04, 8'h01);
    preload(8'h05, 8'h03);
    preload(8'h06, 8'h0A);
    preload(8'h07, 8'h0B);
    preload(8'hFF, 8'h5A);
    preload(8'h00, 8'hC3);

    frame(8'h0B, 24'h000004, 32, -1, cap);
    chk("read_0B_word", 64'(cap[31:0]), 64'h01030A0B);
    frame(8'hBB, 24'h000004, 16, -1, cap);
    chk("read_BB_word", 64'(cap[31:0]), 64'h01030A0B);
    frame(8'hEB, 24'h000004, 8, -1, cap);
    chk("read_EB_word", 64'(cap[31:0]), 64'h01030A0B);
    frame(8'h0B, 24'h0000FF, 16, -1, cap);
    chk("read_wrap", 64'(cap[15:0]), 64'h5AC3);
    frame(8'h9F, 24'h000000, 0, -1, cap);
    frame(8'hEB, 24'h000004, 8, 3, cap);
    frame(8'h0B, 24'h000004, 32, -1, cap);
    chk("read_after_rst", 64'(cap[31:0]), 64'h01030A0B);

    for (int n = 0; n < 20; n++) begin
      preload(8'($urandom), 8'($urandom));
      case ($urandom_range(0, 3))
        0: c = 8'h0B;
        1: c = 8'hBB;
        2: c = 8'hEB;
        default: c = 8'($urandom);
      endcase
      frame(c, 24'($urandom), $urandom_range(1, 40), -1, cap);
    end

    frame(8'hEB, 24'h7A0004, 8, -1, cap);
    chk("read_hi_addr", 64'(cap[31:0]),
        {32'h0, mem_m[4], mem_m[5], mem_m[6], mem_m[7]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
